// File: rtl/prj_definition.sv
// Shared definitions for the cs147sec05 control path.
// CTRL bit map, ALU codes, opcodes/functs and FSM states.
package prj_definition;

   localparam int CTRL_WIDTH = 32;
   localparam int DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEMORY    = 3'd3,
      S_WRITEBACK = 3'd4
   } state_t;

   localparam int B_PC_LOAD   = 0;
   localparam int B_PC_SEL_1  = 1;
   localparam int B_PC_SEL_2  = 2;
   localparam int B_PC_SEL_3  = 3;
   localparam int B_MEM_R     = 4;
   localparam int B_MEM_W     = 5;
   localparam int B_R1_SEL_1  = 6;
   localparam int B_REG_R     = 7;
   localparam int B_REG_W     = 8;
   localparam int B_WA_SEL_1  = 9;
   localparam int B_WA_SEL_2  = 10;
   localparam int B_WA_SEL_3  = 11;
   localparam int B_WD_SEL_1  = 12;
   localparam int B_WD_SEL_2  = 13;
   localparam int B_WD_SEL_3  = 14;
   localparam int B_SP_LOAD   = 15;
   localparam int B_OP1_SEL_1 = 16;
   localparam int B_OP2_SEL_1 = 17;
   localparam int B_OP2_SEL_2 = 18;
   localparam int B_OP2_SEL_3 = 19;
   localparam int B_OP2_SEL_4 = 20;
   localparam int B_MA_SEL_1  = 21;
   localparam int B_MA_SEL_2  = 22;
   localparam int B_MD_SEL_1  = 23;
   localparam int B_IR_LOAD   = 24;
   localparam int B_ALU_LO    = 25;
   localparam int B_ALU_HI    = 30;

   localparam logic [5:0] ALU_NONE = 6'd0;
   localparam logic [5:0] ALU_ADD  = 6'd1;
   localparam logic [5:0] ALU_SUB  = 6'd2;
   localparam logic [5:0] ALU_MUL  = 6'd3;
   localparam logic [5:0] ALU_SRL  = 6'd4;
   localparam logic [5:0] ALU_SLL  = 6'd5;
   localparam logic [5:0] ALU_AND  = 6'd6;
   localparam logic [5:0] ALU_OR   = 6'd7;
   localparam logic [5:0] ALU_NOR  = 6'd8;
   localparam logic [5:0] ALU_SLT  = 6'd9;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_MULI  = 6'h1d;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_JMP   = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_PUSH  = 6'h1b;
   localparam logic [5:0] OP_POP   = 6'h1c;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_MUL = 6'h2c;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2a;
   localparam logic [5:0] FN_SLL = 6'h01;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_JR  = 6'h08;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from the state being entered and the
// instruction fields to the packed datapath control word.
module ctrl_decode
   import prj_definition::*;
(
   input  logic [2:0]            next_state,
   input  logic [5:0]            opcode,
   input  logic [5:0]            funct,
   input  logic                  zero_q,
   output logic [CTRL_WIDTH-1:0] ctrl
);

   logic [5:0] alu;
   logic       op2_r, op2_sh, op2_sx, op2_stk;
   logic       wb_rd, wb_rt, wb_mem, wb_lui;
   logic       is_jr, is_beq, is_bne, is_jmp, is_jal;
   logic       is_lw, is_sw, is_push, is_pop;

   always_comb begin : classify
      alu     = ALU_NONE;
      op2_r   = 1'b0;
      op2_sh  = 1'b0;
      op2_sx  = 1'b0;
      op2_stk = 1'b0;
      wb_rd   = 1'b0;
      wb_rt   = 1'b0;
      wb_mem  = 1'b0;
      wb_lui  = 1'b0;
      is_jr   = 1'b0;
      is_beq  = 1'b0;
      is_bne  = 1'b0;
      is_jmp  = 1'b0;
      is_jal  = 1'b0;
      is_lw   = 1'b0;
      is_sw   = 1'b0;
      is_push = 1'b0;
      is_pop  = 1'b0;
      if (opcode == OP_RTYPE) begin
         wb_rd = 1'b1;
         op2_r = 1'b1;
         case (funct)
            FN_ADD: alu = ALU_ADD;
            FN_SUB: alu = ALU_SUB;
            FN_MUL: alu = ALU_MUL;
            FN_AND: alu = ALU_AND;
            FN_OR:  alu = ALU_OR;
            FN_NOR: alu = ALU_NOR;
            FN_SLT: alu = ALU_SLT;
            FN_SLL: begin
               alu = ALU_SLL; op2_r = 1'b0; op2_sh = 1'b1;
            end
            FN_SRL: begin
               alu = ALU_SRL; op2_r = 1'b0; op2_sh = 1'b1;
            end
            FN_JR: begin
               is_jr = 1'b1; wb_rd = 1'b0; op2_r = 1'b0;
            end
            default: begin
               wb_rd = 1'b0; op2_r = 1'b0;
            end
         endcase
      end else begin
         case (opcode)
            OP_ADDI: begin alu = ALU_ADD; op2_sx = 1'b1; wb_rt = 1'b1; end
            OP_MULI: begin alu = ALU_MUL; op2_sx = 1'b1; wb_rt = 1'b1; end
            OP_SLTI: begin alu = ALU_SLT; op2_sx = 1'b1; wb_rt = 1'b1; end
            OP_ANDI: begin alu = ALU_AND; wb_rt = 1'b1; end
            OP_ORI:  begin alu = ALU_OR;  wb_rt = 1'b1; end
            OP_LUI:  begin wb_rt = 1'b1; wb_lui = 1'b1; end
            OP_BEQ:  begin alu = ALU_SUB; op2_r = 1'b1; is_beq = 1'b1; end
            OP_BNE:  begin alu = ALU_SUB; op2_r = 1'b1; is_bne = 1'b1; end
            OP_LW: begin
               alu = ALU_ADD; op2_sx = 1'b1; is_lw = 1'b1;
               wb_rt = 1'b1; wb_mem = 1'b1;
            end
            OP_SW:   begin alu = ALU_ADD; op2_sx = 1'b1; is_sw = 1'b1; end
            OP_JMP:  is_jmp = 1'b1;
            OP_JAL:  is_jal = 1'b1;
            OP_PUSH: begin alu = ALU_SUB; op2_stk = 1'b1; is_push = 1'b1; end
            OP_POP: begin
               alu = ALU_ADD; op2_stk = 1'b1; is_pop = 1'b1;
               wb_rt = 1'b1; wb_mem = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ALU steering is held from EXECUTE through WRITEBACK so the result stays stable
   always_comb begin : build
      ctrl = '0;
      if (next_state == S_FETCH) begin
         ctrl[B_MEM_R]    = 1'b1;
         ctrl[B_MA_SEL_2] = 1'b1;
         ctrl[B_IR_LOAD]  = 1'b1;
      end
      if (next_state == S_DECODE) begin
         ctrl[B_REG_R]    = 1'b1;
         ctrl[B_R1_SEL_1] = !is_push;
      end
      if (next_state inside {S_EXECUTE, S_MEMORY, S_WRITEBACK}) begin
         ctrl[B_ALU_HI:B_ALU_LO] = alu;
         ctrl[B_OP2_SEL_4] = op2_r;
         ctrl[B_OP2_SEL_3] = op2_sh | op2_stk;
         ctrl[B_OP2_SEL_2] = op2_sx;
         ctrl[B_OP2_SEL_1] = op2_sh;
         ctrl[B_OP1_SEL_1] = op2_stk;
      end
      if (next_state == S_MEMORY) begin
         ctrl[B_MEM_R]    = is_lw | is_pop;
         ctrl[B_MEM_W]    = is_sw | is_push;
         ctrl[B_MA_SEL_1] = is_push | is_pop;
         ctrl[B_MD_SEL_1] = is_push;
      end
      if (next_state == S_WRITEBACK) begin
         ctrl[B_PC_LOAD]  = 1'b1;
         ctrl[B_PC_SEL_1] = !is_jr;
         ctrl[B_PC_SEL_2] = (is_beq & zero_q) | (is_bne & !zero_q);
         ctrl[B_PC_SEL_3] = !(is_jmp | is_jal);
         ctrl[B_REG_W]    = wb_rd | wb_rt | is_jal;
         ctrl[B_WA_SEL_1] = wb_rt;
         ctrl[B_WA_SEL_2] = is_jal;
         ctrl[B_WA_SEL_3] = wb_rd | wb_rt;
         ctrl[B_WD_SEL_1] = wb_mem;
         ctrl[B_WD_SEL_2] = wb_lui;
         ctrl[B_WD_SEL_3] = wb_rd | wb_rt;
         ctrl[B_SP_LOAD]  = is_push | is_pop;
      end
   end

endmodule

// File: rtl/control_unit.sv
// Five-state multi-cycle sequencer for the cs147sec05 core.
// CTRL is registered and always reflects the current state.
module control_unit #(
   parameter int CTRL_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] INSTRUCTION,
   input  logic                  ZERO,
   output logic [CTRL_WIDTH-1:0] CTRL,
   output logic [2:0]            STATE
);

   import prj_definition::*;

   state_t                  state_q;
   state_t                  next_state;
   logic                    run_q;
   logic [DATA_WIDTH-1:0]   ir_q;
   logic [DATA_WIDTH-1:0]   instr_eff;
   logic                    zero_q;
   logic [CTRL_WIDTH-1:0]   ctrl_q;
   logic [CTRL_WIDTH-1:0]   ctrl_d;
   logic                    unused_instr;

   // run_q holds off one cycle after reset so FETCH gets its own strobes
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= S_FETCH;
         run_q   <= 1'b0;
         ir_q    <= '0;
         zero_q  <= 1'b0;
         ctrl_q  <= '0;
      end else begin
         state_q <= next_state;
         run_q   <= 1'b1;
         ctrl_q  <= ctrl_d;
         if (next_state == S_DECODE) ir_q <= INSTRUCTION;
         if (state_q == S_EXECUTE) zero_q <= ZERO;
      end
   end

   always_comb begin
      next_state = S_FETCH;
      if (run_q) begin
         unique case (state_q)
            S_FETCH:     next_state = S_DECODE;
            S_DECODE:    next_state = S_EXECUTE;
            S_EXECUTE:   next_state = S_MEMORY;
            S_MEMORY:    next_state = S_WRITEBACK;
            S_WRITEBACK: next_state = S_FETCH;
            default:     next_state = S_FETCH;
         endcase
      end
   end

   // DECODE strobes are produced on the same edge that captures ir_q
   assign instr_eff = (next_state == S_DECODE) ? INSTRUCTION : ir_q;
   assign unused_instr = ^instr_eff[25:6];

   ctrl_decode u_dec (
      .next_state (next_state),
      .opcode     (instr_eff[31:26]),
      .funct      (instr_eff[5:0]),
      .zero_q     (zero_q),
      .ctrl       (ctrl_d)
   );

   assign CTRL  = ctrl_q;
   assign STATE = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed cases plus
// random instruction streams against a phase-level model.
module tb_control_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] INSTRUCTION;
   logic        ZERO;
   logic [31:0] CTRL;
   logic [2:0]  STATE;

   always #5 CLK = ~CLK;

   control_unit #(
      .CTRL_WIDTH (32),
      .DATA_WIDTH (32)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .INSTRUCTION (INSTRUCTION),
      .ZERO        (ZERO),
      .CTRL        (CTRL),
      .STATE       (STATE)
   );

   int          n_chk = 0;
   int          n_pass = 0;
   int          m_ph = 0;
   bit          m_run = 0;
   logic [31:0] m_ir = '0;
   logic        m_zq = 1'b0;
   logic [31:0] m_ctrl = '0;
   logic [31:0] cap [5];

   logic [5:0] ops [18] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h1d, 6'h0c,
                            6'h0d, 6'h0f, 6'h0a, 6'h04, 6'h05, 6'h23,
                            6'h2b, 6'h02, 6'h03, 6'h1b, 6'h1c, 6'h3f};
   logic [5:0] fns [12] = '{6'h20, 6'h22, 6'h2c, 6'h24, 6'h25, 6'h27,
                            6'h2a, 6'h01, 6'h02, 6'h08, 6'h3f, 6'h00};

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic string mnem(logic [31:0] ins);
      string k;
      k = "nop";
      if (ins[31:26] == 6'h00) begin
         case (ins[5:0])
            6'h20: k = "add";  6'h22: k = "sub";  6'h2c: k = "mul";
            6'h24: k = "and";  6'h25: k = "or";   6'h27: k = "nor";
            6'h2a: k = "slt";  6'h01: k = "sll";  6'h02: k = "srl";
            6'h08: k = "jr";
            default: k = "nop";
         endcase
      end else begin
         case (ins[31:26])
            6'h08: k = "addi"; 6'h1d: k = "muli"; 6'h0c: k = "andi";
            6'h0d: k = "ori";  6'h0f: k = "lui";  6'h0a: k = "slti";
            6'h04: k = "beq";  6'h05: k = "bne";  6'h23: k = "lw";
            6'h2b: k = "sw";   6'h02: k = "jmp";  6'h03: k = "jal";
            6'h1b: k = "push"; 6'h1c: k = "pop";
            default: k = "nop";
         endcase
      end
      return k;
   endfunction

   // Expected CTRL for a phase (0..4) of instruction ins, from the bit map
   function automatic logic [31:0] exp_ctrl(int ph, logic [31:0] ins,
                                            logic zq);
      logic [31:0] c;
      string k;
      int alu;
      bit rr, rd, iw, sx;
      c = '0; alu = 0; rr = 0; rd = 0; iw = 0; sx = 0;
      k = mnem(ins);
      case (k)
         "add", "addi", "lw", "sw", "pop": alu = 1;
         "sub", "beq", "bne", "push":      alu = 2;
         "mul", "muli":  alu = 3;
         "srl":          alu = 4;
         "sll":          alu = 5;
         "and", "andi":  alu = 6;
         "or", "ori":    alu = 7;
         "nor":          alu = 8;
         "slt", "slti":  alu = 9;
         default:        alu = 0;
      endcase
      case (k)
         "add", "sub", "mul", "and", "or", "nor", "slt": begin
            rr = 1; rd = 1;
         end
         "sll", "srl": rd = 1;
         default: ;
      endcase
      case (k)
         "addi", "muli", "slti", "lw", "sw": sx = 1;
         default: ;
      endcase
      case (k)
         "addi", "muli", "andi", "ori", "slti", "lui", "lw", "pop": iw = 1;
         default: ;
      endcase
      if (ph == 0) begin
         c[4] = 1; c[22] = 1; c[24] = 1;
      end else if (ph == 1) begin
         c[7] = 1; c[6] = (k != "push");
      end else begin
         c[30:25] = alu[5:0];
         if (rr || k == "beq" || k == "bne") c[20] = 1;
         if (k == "sll" || k == "srl") begin c[19] = 1; c[17] = 1; end
         if (sx) c[18] = 1;
         if (k == "push" || k == "pop") begin c[16] = 1; c[19] = 1; end
      end
      if (ph == 3) begin
         if (k == "lw")   c[4] = 1;
         if (k == "sw")   c[5] = 1;
         if (k == "push") begin c[5] = 1; c[21] = 1; c[23] = 1; end
         if (k == "pop")  begin c[4] = 1; c[21] = 1; end
      end
      if (ph == 4) begin
         c[0] = 1;
         c[1] = (k != "jr");
         c[3] = !(k == "jmp" || k == "jal");
         if (k == "beq") c[2] = zq;
         if (k == "bne") c[2] = !zq;
         if (rd) begin c[8] = 1; c[11] = 1; c[14] = 1; end
         if (iw) begin c[8] = 1; c[9] = 1; c[11] = 1; c[14] = 1; end
         if (k == "lw" || k == "pop") c[12] = 1;
         if (k == "lui") c[13] = 1;
         if (k == "push" || k == "pop") c[15] = 1;
         if (k == "jal") begin c[8] = 1; c[10] = 1; end
      end
      return c;
   endfunction

   task automatic model_edge();
      int nxt;
      if (!RST) begin
         m_ph = 0; m_run = 0; m_ir = '0; m_zq = 1'b0; m_ctrl = '0;
      end else begin
         if (m_ph == 2) m_zq = ZERO;
         nxt = m_run ? (m_ph + 1) % 5 : 0;
         m_run = 1;
         if (nxt == 1) m_ir = INSTRUCTION;
         m_ph = nxt;
         m_ctrl = exp_ctrl(m_ph, m_ir, m_zq);
      end
   endtask

   task automatic cycle();
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      check("state", {29'd0, STATE}, m_ph);
      check("ctrl", CTRL, m_ctrl);
      if (m_run) cap[m_ph] = CTRL;
   endtask

   // Call while in FETCH; runs one full instruction back to FETCH
   task automatic run_instr(logic [31:0] ins, logic z);
      INSTRUCTION = ins;
      ZERO = z;
      repeat (5) cycle();
   endtask

   initial begin
      logic [31:0] r;
      RST = 1'b0;
      INSTRUCTION = '0;
      ZERO = 1'b0;
      @(negedge CLK);
      cycle();
      cycle();
      check("rst_ctrl", CTRL, 32'h0);
      check("rst_state", {29'd0, STATE}, 32'd0);
      RST = 1'b1;
      cycle();
      check("first_fetch", CTRL, 32'h0140_0010);

      run_instr(32'h0022_1820, 1'b0);
      check("add_ex_alu", {26'd0, cap[2][30:25]}, 32'd1);
      check("add_ex_op2", {31'd0, cap[2][20]}, 32'd1);
      check("add_wb_regw", {31'd0, cap[4][8]}, 32'd1);
      check("add_wb_wa3", {31'd0, cap[4][11]}, 32'd1);
      check("add_wb_wa1", {31'd0, cap[4][9]}, 32'd0);
      check("add_wb_pcld", {31'd0, cap[4][0]}, 32'd1);
      check("add_back", {29'd0, STATE}, 32'd0);

      run_instr(32'h1022_0003, 1'b1);
      check("beq_z1", {31'd0, cap[4][2]}, 32'd1);
      check("beq_alu", {26'd0, cap[4][30:25]}, 32'd2);
      run_instr(32'h1022_0003, 1'b0);
      check("beq_z0", {31'd0, cap[4][2]}, 32'd0);
      run_instr(32'h1422_0003, 1'b1);
      check("bne_z1", {31'd0, cap[4][2]}, 32'd0);
      run_instr(32'h1422_0003, 1'b0);
      check("bne_z0", {31'd0, cap[4][2]}, 32'd1);

      run_instr(32'hAC22_0004, 1'b0);
      check("sw_memw", {31'd0, cap[3][5]}, 32'd1);
      check("sw_md", {31'd0, cap[3][23]}, 32'd0);
      check("sw_regw", {31'd0, cap[3][8]}, 32'd0);
      run_instr(32'h8C22_0004, 1'b0);
      check("lw_memr", {31'd0, cap[3][4]}, 32'd1);
      check("lw_wd1", {31'd0, cap[4][12]}, 32'd1);
      check("lw_regw", {31'd0, cap[4][8]}, 32'd1);

      run_instr(32'h0C00_0010, 1'b0);
      check("jal_pc3", {31'd0, cap[4][3]}, 32'd0);
      check("jal_wa2", {31'd0, cap[4][10]}, 32'd1);
      check("jal_wa3", {31'd0, cap[4][11]}, 32'd0);
      check("jal_wd3", {31'd0, cap[4][14]}, 32'd0);
      check("jal_regw", {31'd0, cap[4][8]}, 32'd1);
      run_instr(32'h6C01_0000, 1'b0);
      check("push_memw", {31'd0, cap[3][5]}, 32'd1);
      check("push_ma1", {31'd0, cap[3][21]}, 32'd1);
      check("push_sp", {31'd0, cap[4][15]}, 32'd1);

      run_instr(32'hFC00_0000, 1'b0);
      check("nop_dec", cap[1], 32'h0000_00C0);
      check("nop_ex", cap[2], 32'h0);
      check("nop_mem", cap[3], 32'h0);
      check("nop_wb", cap[4], 32'h0000_000B);

      INSTRUCTION = 32'hAC22_0004;
      repeat (3) cycle();
      check("abort_pre", {31'd0, CTRL[5]}, 32'd1);
      RST = 1'b0;
      cycle();
      check("abort_state", {29'd0, STATE}, 32'd0);
      check("abort_ctrl", CTRL, 32'h0);
      RST = 1'b1;
      INSTRUCTION = 32'h0022_1820;
      repeat (10) begin
         cycle();
         check("abort_memw", {31'd0, CTRL[5]}, 32'd0);
      end

      for (int i = 0; i < 2000; i++) begin
         if (m_ph == 0) begin
            r = $urandom();
            INSTRUCTION = {ops[$urandom_range(0, 17)], r[25:6],
                           fns[$urandom_range(0, 11)]};
         end
         ZERO = 1'($urandom_range(0, 1));
         RST = ($urandom_range(0, 39) != 0);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
